// File: rtl/nios_debug_ocimem_arbiter_if.sv
// CPU debug-memory slave bus into the OCI RAM arbiter.
// The master modport is the CPU side and the slave modport is the arbiter.
interface nios_debug_ocimem_arbiter_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [31:0]           writedata;
  logic [3:0]            byteenable;
  logic                  waitrequest;
  logic [31:0]           readdata;
  logic                  readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between a one-deep JTAG command slot
// and the CPU debug slave, with round-robin arbitration on ties.
module nios_debug_ocimem_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic [37:0]           jdo,
  nios_debug_ocimem_arbiter_if.slave cpu,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_wren,
  output logic [3:0]            ram_byteenable,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [31:0]           MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    JTAG_RD
  } state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_JTAG
  } grant_t;

  state_t                state;
  grant_t                last_grant;
  logic [ADDR_WIDTH-1:0] jtag_addr;
  logic                  slot_valid;
  logic                  slot_write;
  logic [31:0]           slot_data;

  logic cpu_req;
  logic jtag_req;
  logic grant_cpu;
  logic grant_jtag;
  logic jtag_done;
  logic jtag_queue;
  logic jtag_overrun;
  logic jdo_unused;

  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  // Grants only happen in IDLE, and never while reset is held.
  always_comb begin
    cpu_req    = cpu.read | cpu.write;
    jtag_req   = slot_valid && (state == IDLE);
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (reset_n && (state == IDLE)) begin
      if (cpu_req && jtag_req) begin
        grant_cpu  = (last_grant == GRANT_JTAG);
        grant_jtag = (last_grant == GRANT_CPU);
      end else begin
        grant_cpu  = cpu_req;
        grant_jtag = jtag_req;
      end
    end
  end

  // A JTAG command retires on its write grant or in the read-capture cycle.
  always_comb begin
    jtag_done    = (grant_jtag && slot_write) || (state == JTAG_RD);
    jtag_queue   = !take_action_ocimem_a &&
                   (take_action_ocimem_b || take_no_action_ocimem_a) && !slot_valid;
    jtag_overrun = !take_action_ocimem_a &&
                   (take_action_ocimem_b || take_no_action_ocimem_a) && slot_valid;
  end

  always_comb begin
    ram_address    = '0;
    ram_wren       = 1'b0;
    ram_byteenable = 4'h0;
    ram_wdata      = 32'h0;
    if (grant_cpu) begin
      ram_address    = cpu.address;
      ram_wren       = cpu.write;
      ram_byteenable = cpu.byteenable;
      ram_wdata      = cpu.write ? cpu.writedata : 32'h0;
    end else if (grant_jtag) begin
      ram_address    = jtag_addr;
      ram_wren       = slot_write;
      ram_byteenable = 4'hF;
      ram_wdata      = slot_write ? slot_data : 32'h0;
    end
  end

  assign cpu.waitrequest   = ~grant_cpu;
  assign cpu.readdatavalid = (state == CPU_RD);
  assign cpu.readdata      = (state == CPU_RD) ? ram_rdata : 32'h0;
  assign monitor_ready     = ~slot_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= GRANT_JTAG;
      jtag_addr     <= '0;
      slot_valid    <= 1'b0;
      slot_write    <= 1'b0;
      slot_data     <= 32'h0;
      MonDReg       <= 32'h0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_cpu && cpu.read) begin
            state <= CPU_RD;
          end else if (grant_jtag && !slot_write) begin
            state <= JTAG_RD;
          end
        end
        CPU_RD: begin
          state <= IDLE;
        end
        JTAG_RD: begin
          MonDReg <= ram_rdata;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (grant_cpu) begin
        last_grant <= GRANT_CPU;
      end else if (grant_jtag) begin
        last_grant <= GRANT_JTAG;
      end

      // An explicit address load from the host takes precedence over auto-increment.
      if (take_action_ocimem_a) begin
        jtag_addr <= jdo[17+ADDR_WIDTH-1:17];
      end else if (jtag_done) begin
        jtag_addr <= jtag_addr + 1'b1;
      end

      if (take_action_ocimem_a) begin
        monitor_error <= 1'b0;
      end else if (jtag_overrun) begin
        monitor_error <= 1'b1;
      end

      if (jtag_queue) begin
        slot_valid <= 1'b1;
        slot_write <= take_action_ocimem_b;
        slot_data  <= take_action_ocimem_b ? jdo[34:3] : 32'h0;
      end else if (jtag_done) begin
        slot_valid <= 1'b0;
      end
    end
  end

endmodule
